frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Per-frame controller for the depth-tested write path. Sequences CLEAR → DRAW → DRAIN → SWAP each frame.
- Drives the depth writer's request bus: drawing, fb/dp enables, addresses and values, and front-buffer select.
- During CLEAR it sweeps every pixel itself. During DRAW it grants the bus to the rasterizer through a valid/ready handshake.
- Sits between the rasterizer and the depth writer; frame start is paced by the display's vsync.

Parameters:
- FB_BIT_WIDTH, 16, framebuffer pixel width.
- DEPTH_BIT_WIDTH, 16, depth word width.
- FB_ADDR_WIDTH, 17, pixel address width.
- FB_SIZE, 76800, pixels per buffer (320x240).
- PIPE_LATENCY, 4, depth-writer input-to-write latency in cycles.
- CLEAR_COLOR, 0, framebuffer clear value (FB_BIT_WIDTH bits).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- frame_start_in  input  1  single-cycle pulse (vsync) requesting a new frame
- rast_valid_in  input  1  rasterizer pixel request valid
- rast_ready_out  output  1  sequencer accepts rasterizer pixel
- rast_addr_in  input  FB_ADDR_WIDTH  pixel address
- rast_color_in  input  FB_BIT_WIDTH  pixel colour
- rast_depth_in  input  DEPTH_BIT_WIDTH  pixel depth (smaller = nearer)
- rast_done_in  input  1  pulse: rasterizer finished the frame
- rast_start_out  output  1  single-cycle pulse: rasterizer may begin
- drawing_out  output  1  to depth writer: 1 = depth-tested, 0 = raw pass-through
- fb_we_out  output  1  framebuffer write request
- dp_we_out  output  1  depth buffer write request
- dp_re_out  output  1  depth buffer read request
- fb_front_out  output  1  front (display) buffer select
- fb_write_out  output  FB_ADDR_WIDTH  framebuffer address
- fb_value_out  output  FB_BIT_WIDTH  framebuffer data
- dp_write_out  output  FB_ADDR_WIDTH  depth address
- dp_value_out  output  DEPTH_BIT_WIDTH  depth data
- busy_out  output  1  high in any state except IDLE
- frame_done_out  output  1  single-cycle pulse at buffer swap
- overrun_out  output  1  single-cycle pulse: frame_start_in arrived while busy

Behaviour:
- Reset (rst_in=0 at a clock edge) forces:
  - state IDLE.
  - All outputs 0, including fb_front_out=0 and rast_ready_out=0.
  - Clear counter 0 and drain counter 0.
- Reset takes effect mid-operation with no completion; in-flight pixels are discarded.
- All outputs are registered.
- States: IDLE, CLEAR, DRAW, DRAIN, SWAP.
- IDLE:
  - All enables 0.
  - frame_start_in → CLEAR next cycle, with clear counter = 0.
- CLEAR:
  - One pixel issued per cycle for addr 0..FB_SIZE-1, so FB_SIZE cycles total.
  - Outputs per pixel: drawing_out=0, fb_we_out=dp_we_out=1, dp_re_out=0, fb_write_out=dp_write_out=addr, fb_value_out=CLEAR_COLOR, dp_value_out=DEPTH_FAR (all ones).
  - After issuing addr FB_SIZE-1 → DRAW, with a one-cycle rast_start_out pulse on entry.
- DRAW:
  - rast_ready_out=1.
  - A handshake (valid&&ready) in cycle N produces, in cycle N+1: drawing_out=1, fb_we_out=dp_we_out=dp_re_out=1, fb_write_out=dp_write_out=rast_addr_in, fb_value_out=rast_color_in, dp_value_out=rast_depth_in.
  - With no handshake, all enables are 0 and drawing_out stays 1.
  - rast_done_in → DRAIN next cycle and rast_ready_out drops.
  - A valid pixel in the same cycle as rast_done_in is still accepted.
- DRAIN:
  - All enables 0, drawing_out=1.
  - Waits PIPE_LATENCY+1 cycles so the last tested write retires, then → SWAP.
- SWAP:
  - One cycle: fb_front_out toggles and frame_done_out=1, then → IDLE.
- fb_front_out is constant outside SWAP.
- frame_start_in in any state other than IDLE is ignored and pulses overrun_out; the state is unchanged.
- frame_start_in in the same cycle as SWAP also counts as an overrun.
- rast_done_in outside DRAW is ignored.
- The clear counter is FB_ADDR_WIDTH bits and compares against FB_SIZE-1; it never wraps.
- FB_SIZE must be ≤ 2^FB_ADDR_WIDTH (elaboration-time check).
- Outside CLEAR and DRAW accept cycles, the address and value outputs hold their last value.

Decomposition:
- Package frame_seq_pkg holds:
  - the state enum (IDLE, CLEAR, DRAW, DRAIN, SWAP);
  - DEPTH_FAR as a function of width;
  - a localparam for the DRAIN length.
- One natural sub-module, clear_sweeper: a counter with start/last handshake producing the sweep address and a last-pixel flag.
- The FSM and output registers stay in frame_sequencer.

Test Plan (FB_SIZE=8, PIPE_LATENCY=4):
- Reset then frame_start pulse:
  - 8 consecutive cycles with fb_we=dp_we=1, drawing=0, addr 0..7, dp_value=16'hFFFF, fb_value=0.
  - Then a rast_start pulse.
- DRAW, valid with addr=5, color=16'h1234, depth=16'h0100: the next cycle shows drawing=1, all three enables=1, fb_write=dp_write=5, values 16'h1234 and 16'h0100.
- rast_done coincident with a final valid (addr 7):
  - The pixel is issued.
  - Then 5 idle DRAIN cycles.
  - Then fb_front 0→1 with frame_done high for 1 cycle.
  - busy drops the cycle after.
- frame_start during CLEAR at addr 3: overrun pulses for one cycle and the sweep continues to addr 7 unaffected.
- rst_in=0 during DRAW: the next cycle shows all outputs 0, state IDLE and fb_front=0; a fresh frame_start restarts the sweep at addr 0.
- Two full frames back-to-back: fb_front goes 0→1→0; rast_valid before rast_start is not accepted (rast_ready=0).

Source files
------------

// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared types and constants for the frame sequencer.
// State encoding, far-plane depth helper and drain length.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_DRAW  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SWAP  = 3'd4
  } state_e;

  // Extra cycle past the writer latency so the last
  // tested write has fully retired before the swap.
  localparam int unsigned DRAIN_SLACK = 1;

  function automatic int unsigned drain_len(
    input int unsigned pipe_latency
  );
    return pipe_latency + DRAIN_SLACK;
  endfunction

  // All-ones depth of the given width (farthest value).
  function automatic logic [63:0] depth_far(
    input int unsigned w
  );
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: rasterizer handshake and depth-writer request bus.
// master = sequencer side, slave = rasterizer/depth-writer side.
interface frame_sequencer_if #(
  parameter int FB_BIT_WIDTH    = 16,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int FB_ADDR_WIDTH   = 17
);

  logic                       rast_valid_in;
  logic                       rast_ready_out;
  logic [FB_ADDR_WIDTH-1:0]   rast_addr_in;
  logic [FB_BIT_WIDTH-1:0]    rast_color_in;
  logic [DEPTH_BIT_WIDTH-1:0] rast_depth_in;
  logic                       rast_done_in;
  logic                       rast_start_out;

  logic                       drawing_out;
  logic                       fb_we_out;
  logic                       dp_we_out;
  logic                       dp_re_out;
  logic                       fb_front_out;
  logic [FB_ADDR_WIDTH-1:0]   fb_write_out;
  logic [FB_BIT_WIDTH-1:0]    fb_value_out;
  logic [FB_ADDR_WIDTH-1:0]   dp_write_out;
  logic [DEPTH_BIT_WIDTH-1:0] dp_value_out;

  modport master (
    input  rast_valid_in,
    input  rast_addr_in,
    input  rast_color_in,
    input  rast_depth_in,
    input  rast_done_in,
    output rast_ready_out,
    output rast_start_out,
    output drawing_out,
    output fb_we_out,
    output dp_we_out,
    output dp_re_out,
    output fb_front_out,
    output fb_write_out,
    output fb_value_out,
    output dp_write_out,
    output dp_value_out
  );

  modport slave (
    output rast_valid_in,
    output rast_addr_in,
    output rast_color_in,
    output rast_depth_in,
    output rast_done_in,
    input  rast_ready_out,
    input  rast_start_out,
    input  drawing_out,
    input  fb_we_out,
    input  dp_we_out,
    input  dp_re_out,
    input  fb_front_out,
    input  fb_write_out,
    input  fb_value_out,
    input  dp_write_out,
    input  dp_value_out
  );

endinterface

// File: rtl/clear_sweeper.sv
// clear_sweeper: pixel address counter for the CLEAR sweep.
// start_in loads 0, en_in advances; saturates at SIZE-1 (last_out).
module clear_sweeper #(
  parameter int ADDR_W = 17,
  parameter int SIZE   = 76800
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              en_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last_out
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  assign addr_out = cnt_q;
  assign last_out = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (start_in) begin
      cnt_d = '0;
    end else if (en_in && !last_out) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame CLEAR/DRAW/DRAIN/SWAP controller.
// Ports: clk/rst, vsync frame_start, bus (master), busy/done/overrun.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int FB_BIT_WIDTH    = 16,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int FB_ADDR_WIDTH   = 17,
  parameter int FB_SIZE         = 76800,
  parameter int PIPE_LATENCY    = 4,
  parameter logic [FB_BIT_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic frame_start_in,
  frame_sequencer_if.master bus,
  output logic busy_out,
  output logic frame_done_out,
  output logic overrun_out
);

  localparam int DRAIN_CYCLES = int'(drain_len(PIPE_LATENCY));
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [DEPTH_BIT_WIDTH-1:0] DEPTH_FAR =
    DEPTH_BIT_WIDTH'(depth_far(DEPTH_BIT_WIDTH));

  if (longint'(FB_SIZE) > (longint'(1) << FB_ADDR_WIDTH)) begin : g_chk
    $error("FB_SIZE does not fit in FB_ADDR_WIDTH");
  end

  state_e state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;

  logic ready_q, ready_d;
  logic start_q, start_d;
  logic drawing_q, drawing_d;
  logic we_q, we_d;
  logic re_q, re_d;
  logic front_q, front_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ovr_q, ovr_d;
  logic [FB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FB_BIT_WIDTH-1:0] fbv_q, fbv_d;
  logic [DEPTH_BIT_WIDTH-1:0] dpv_q, dpv_d;

  logic sweep_start;
  logic sweep_en;
  logic sweep_last;
  logic [FB_ADDR_WIDTH-1:0] sweep_addr;

  clear_sweeper #(
    .ADDR_W (FB_ADDR_WIDTH),
    .SIZE   (FB_SIZE)
  ) u_sweep (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (sweep_start),
    .en_in    (sweep_en),
    .addr_out (sweep_addr),
    .last_out (sweep_last)
  );

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    sweep_start = 1'b0;
    sweep_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start_in) begin
          state_d     = ST_CLEAR;
          sweep_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        sweep_en = 1'b1;
        if (sweep_last) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        drain_d = '0;
        if (bus.rast_done_in) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q == DRN_LAST) begin
          state_d = ST_SWAP;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_SWAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic clr_px;
  logic accept;

  assign clr_px = (state_q == ST_CLEAR);
  assign accept = (state_q == ST_DRAW) && ready_q
                  && bus.rast_valid_in;

  // Handshake/status flags track the next state so they line
  // up with it; pixel fields are a registered copy of this cycle.
  always_comb begin
    ready_d   = (state_d == ST_DRAW);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_SWAP);
    front_d   = front_q ^ done_d;
    start_d   = clr_px && sweep_last;
    ovr_d     = frame_start_in && (state_q != ST_IDLE);
    drawing_d = (state_q == ST_DRAW) || (state_q == ST_DRAIN);
    we_d      = clr_px || accept;
    re_d      = accept;
    addr_d    = addr_q;
    fbv_d     = fbv_q;
    dpv_d     = dpv_q;
    unique case (1'b1)
      clr_px: begin
        addr_d = sweep_addr;
        fbv_d  = CLEAR_COLOR;
        dpv_d  = DEPTH_FAR;
      end
      accept: begin
        addr_d = bus.rast_addr_in;
        fbv_d  = bus.rast_color_in;
        dpv_d  = bus.rast_depth_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      ready_q   <= 1'b0;
      start_q   <= 1'b0;
      drawing_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      front_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      addr_q    <= '0;
      fbv_q     <= '0;
      dpv_q     <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      ready_q   <= ready_d;
      start_q   <= start_d;
      drawing_q <= drawing_d;
      we_q      <= we_d;
      re_q      <= re_d;
      front_q   <= front_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      addr_q    <= addr_d;
      fbv_q     <= fbv_d;
      dpv_q     <= dpv_d;
    end
  end

  assign bus.rast_ready_out = ready_q;
  assign bus.rast_start_out = start_q;
  assign bus.drawing_out    = drawing_q;
  assign bus.fb_we_out      = we_q;
  assign bus.dp_we_out      = we_q;
  assign bus.dp_re_out      = re_q;
  assign bus.fb_front_out   = front_q;
  assign bus.fb_write_out   = addr_q;
  assign bus.dp_write_out   = addr_q;
  assign bus.fb_value_out   = fbv_q;
  assign bus.dp_value_out   = dpv_q;
  assign busy_out           = busy_q;
  assign frame_done_out     = done_q;
  assign overrun_out        = ovr_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed bench with a timeline model of the frame.
// Checks every output on every cycle plus hand-computed spot values.
module tb_frame_sequencer;

  localparam int FBW   = 16;
  localparam int DPW   = 16;
  localparam int AW    = 17;
  localparam int FBN   = 8;
  localparam int PIPE  = 4;
  localparam int DRAIN = PIPE + 1;

  logic clk = 1'b0;
  logic rst_in;
  logic frame_start_in;
  logic busy_out;
  logic frame_done_out;
  logic overrun_out;

  frame_sequencer_if #(
    .FB_BIT_WIDTH    (FBW),
    .DEPTH_BIT_WIDTH (DPW),
    .FB_ADDR_WIDTH   (AW)
  ) bus ();

  frame_sequencer #(
    .FB_BIT_WIDTH    (FBW),
    .DEPTH_BIT_WIDTH (DPW),
    .FB_ADDR_WIDTH   (AW),
    .FB_SIZE         (FBN),
    .PIPE_LATENCY    (PIPE),
    .CLEAR_COLOR     (16'h0000)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .bus            (bus),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .overrun_out    (overrun_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Timeline model: s = edge a frame was accepted, d = edge
  // rast_done was taken; everything else is offset arithmetic.
  initial begin
    int e, s, d, rel;
    bit active, done_seen, in_draw, acc, clr;
    bit m_ready, m_start, m_draw, m_we, m_re, m_front;
    bit m_busy, m_done, m_ovr;
    logic [AW-1:0] m_addr;
    logic [FBW-1:0] m_fbv;
    logic [DPW-1:0] m_dpv;
    logic [127:0] act_v, exp_v;
    e = 0; s = 0; d = 0;
    active = 0; done_seen = 0; m_front = 0;
    m_addr = '0; m_fbv = '0; m_dpv = '0;
    forever begin
      @(posedge clk);
      e++;
      m_ready = 0; m_start = 0; m_draw = 0; m_we = 0; m_re = 0;
      m_busy = 0; m_done = 0; m_ovr = 0;
      if (!rst_in) begin
        active = 0; done_seen = 0; m_front = 0;
        m_addr = '0; m_fbv = '0; m_dpv = '0;
      end else begin
        m_ovr = frame_start_in && active;
        in_draw = active && (e - 1 >= s + FBN) && !done_seen;
        m_draw = active && (e - 1 >= s + FBN)
                 && (!done_seen || e - 1 <= d + DRAIN - 1);
        acc = in_draw && bus.rast_valid_in;
        if (in_draw && bus.rast_done_in) begin
          done_seen = 1; d = e;
        end
        m_done = active && done_seen && (e == d + DRAIN);
        if (m_done) m_front = ~m_front;
        if (active && done_seen && e == d + DRAIN + 1) begin
          active = 0;
        end else if (!active && frame_start_in) begin
          active = 1; s = e; done_seen = 0;
        end
        rel = e - s;
        m_busy  = active;
        m_ready = active && rel >= FBN && !done_seen;
        m_start = active && rel == FBN;
        clr = active && rel >= 1 && rel <= FBN;
        if (clr) begin
          m_we = 1;
          m_addr = AW'(rel - 1);
          m_fbv = 16'h0000;
          m_dpv = 16'hFFFF;
        end else if (acc) begin
          m_we = 1; m_re = 1;
          m_addr = bus.rast_addr_in;
          m_fbv = bus.rast_color_in;
          m_dpv = bus.rast_depth_in;
        end
      end
      #1;
      exp_v = {52'd0, m_ready, m_start, m_draw, m_we, m_we, m_re,
               m_front, m_busy, m_done, m_ovr,
               m_addr, m_fbv, m_addr, m_dpv};
      act_v = {52'd0, bus.rast_ready_out, bus.rast_start_out,
               bus.drawing_out, bus.fb_we_out, bus.dp_we_out,
               bus.dp_re_out, bus.fb_front_out, busy_out,
               frame_done_out, overrun_out,
               bus.fb_write_out, bus.fb_value_out,
               bus.dp_write_out, bus.dp_value_out};
      check($sformatf("cycle %0d outputs", e), act_v, exp_v);
    end
  end

  task automatic pix(input bit v, input int a,
                     input int c, input int z, input bit dn);
    bus.rast_valid_in = v;
    bus.rast_addr_in  = AW'(a);
    bus.rast_color_in = FBW'(c);
    bus.rast_depth_in = DPW'(z);
    bus.rast_done_in  = dn;
  endtask

  task automatic wait_start(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      frame_start_in = 0;
      if (bus.rast_start_out) begin
        ok = 1;
        break;
      end
    end
    check({name, " start seen"}, 128'(ok), 128'd1);
  endtask

  task automatic wait_swap(input string name, input bit front);
    int k;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pix(0, 0, 0, 0, 0);
      k++;
      if (frame_done_out) break;
    end
    check({name, " done latency"}, 128'(k), 128'd5);
    check({name, " front"}, 128'(bus.fb_front_out), 128'(front));
    @(negedge clk);
    check({name, " busy after"}, 128'(busy_out), 128'd0);
  endtask

  initial begin
    int cnt, last;
    bit ok;
    rst_in = 0;
    frame_start_in = 0;
    pix(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset busy", 128'(busy_out), 128'd0);
    check("reset front", 128'(bus.fb_front_out), 128'd0);
    rst_in = 1;
    @(negedge clk);

    // Frame 1: sweep, one pixel, done with a last pixel.
    frame_start_in = 1;
    cnt = 0; last = -1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      frame_start_in = 0;
      if (bus.fb_we_out && !bus.drawing_out) begin
        cnt++;
        last = int'(bus.fb_write_out);
      end
      if (bus.rast_start_out) begin
        ok = 1;
        break;
      end
    end
    check("f1 start seen", 128'(ok), 128'd1);
    check("f1 clear count", 128'(cnt), 128'd8);
    check("f1 clear last", 128'(last), 128'd7);
    pix(1, 5, 'h1234, 'h0100, 0);
    @(negedge clk);
    pix(0, 0, 0, 0, 0);
    check("f1 px5 addr", 128'(bus.dp_write_out), 128'd5);
    check("f1 px5 color", 128'(bus.fb_value_out), 128'h1234);
    check("f1 px5 depth", 128'(bus.dp_value_out), 128'h0100);
    check("f1 px5 re", 128'(bus.dp_re_out), 128'd1);
    @(negedge clk);
    pix(1, 7, 'hBEEF, 'h0007, 1);
    @(negedge clk);
    pix(0, 0, 0, 0, 0);
    check("f1 px7 addr", 128'(bus.fb_write_out), 128'd7);
    check("f1 ready drop", 128'(bus.rast_ready_out), 128'd0);
    wait_swap("f1", 1);

    // Frame 2: early valid ignored, overrun at addr 3.
    frame_start_in = 1;
    pix(1, 1, 'h5555, 'h0001, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      frame_start_in = 0;
      if (bus.fb_we_out && bus.fb_write_out == AW'(3)) begin
        ok = 1;
        break;
      end
    end
    check("f2 addr3 seen", 128'(ok), 128'd1);
    frame_start_in = 1;
    bus.rast_done_in = 1;
    @(negedge clk);
    frame_start_in = 0;
    bus.rast_done_in = 0;
    check("f2 overrun", 128'(overrun_out), 128'd1);
    check("f2 ready in clear", 128'(bus.rast_ready_out), 128'd0);
    wait_start("f2");
    pix(0, 0, 0, 0, 1);
    @(negedge clk);
    pix(0, 0, 0, 0, 0);
    wait_swap("f2", 0);

    // Frame 3: reset during DRAW, then restart.
    frame_start_in = 1;
    wait_start("f3");
    pix(1, 2, 'hABCD, 'h0042, 0);
    @(negedge clk);
    pix(0, 0, 0, 0, 0);
    rst_in = 0;
    @(negedge clk);
    rst_in = 1;
    check("rst busy", 128'(busy_out), 128'd0);
    check("rst we", 128'(bus.fb_we_out), 128'd0);
    check("rst addr", 128'(bus.fb_write_out), 128'd0);
    check("rst front", 128'(bus.fb_front_out), 128'd0);
    frame_start_in = 1;
    @(negedge clk);
    frame_start_in = 0;
    @(negedge clk);
    check("f4 first we", 128'(bus.fb_we_out), 128'd1);
    check("f4 first addr", 128'(bus.fb_write_out), 128'd0);
    wait_start("f4");
    pix(1, 6, 'h0F0F, 'h0003, 1);
    @(negedge clk);
    pix(0, 0, 0, 0, 0);
    wait_swap("f4", 1);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
